i2c_bus_arbiter: RTL and testbench
==================================

# i2c_bus_arbiter

Round-robin arbiter and transaction sequencer that shares the single I2C bus master between up to NUM_REQ on-chip requesters (for example the FIFO slave's producer and consumer agents and test controllers). It accepts one single-byte command per grant: 7-bit slave address, R/W bit and write byte. It hands the command to the master's command port, waits for completion, and returns read data and status to the granted requester. It sits between the requester logic and the I2C master, in the system clock domain.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 1024: maximum clk cycles in WAIT before a transaction is aborted (timeout build only).
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid; held until the matching req_ready.
- req_addr  in  7*NUM_REQ  slave address; requester i uses bits [7i+6:7i].
- req_rw  in  NUM_REQ  1 = read, 0 = write.
- req_wdata  in  8*NUM_REQ  write byte; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot.
- rsp_rdata  out  8  read byte; valid with rsp_valid.
- rsp_status  out  2  00 OK, 01 NACK, 10 TIMEOUT; valid with rsp_valid.
- grant_id  out  clog2(NUM_REQ)  index of the current or last grant.
- m_start  out  1  one-cycle command strobe to the master.
- m_addr  out  7  address to the master; held from ISSUE through WAIT.
- m_rw  out  1  R/W bit to the master; held from ISSUE through WAIT.
- m_wdata  out  8  write byte to the master; held from ISSUE through WAIT.
- m_abort  out  1  one-cycle abort strobe to the master (timeout build only).
- m_busy  in  1  master transaction in progress.
- m_done  in  1  one-cycle completion pulse from the master.
- m_ack  in  1  slave ACKed the address and data; sampled with m_done.
- m_rdata  in  8  read byte; sampled with m_done.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, choose the winner by round-robin, searching from (last_grant+1) mod NUM_REQ upward and wrapping.
  - Latch the winner's address, R/W bit and write byte into m_addr, m_rw, m_wdata; set grant_id; go to ISSUE.
  - last_grant resets to NUM_REQ-1, so requester 0 has first priority after reset.
- ISSUE:
  - req_ready[grant_id] is high for exactly this cycle.
  - If m_busy is low, pulse m_start and go to WAIT; otherwise stay in ISSUE.
- WAIT: on m_done, capture m_ack and m_rdata, then go to RESP.
- RESP:
  - Pulse rsp_valid[grant_id].
  - rsp_status = 00 if m_ack, else 01.
  - rsp_rdata = m_rdata when the status is OK and m_rw is 1; otherwise rsp_rdata = 0.
  - Update last_grant to grant_id; go to IDLE.
- Only one transaction is outstanding at a time. Requests that are not granted wait; there is no queuing inside the block.
- A req_valid deasserted after capture does not cancel the transaction; the command completes and its response is still issued.
- A single requester holding req_valid continuously is granted every turn. With several requesters active, grants rotate strictly in order.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_status=00, grant_id=0, m_start=0, m_addr=0, m_rw=0, m_wdata=0, m_abort=0.
- After reset the FSM is in IDLE and last_grant = NUM_REQ-1.
- Latency, req_valid high in IDLE to req_ready: 1 cycle.
- Latency, req_ready to m_start: the same cycle when m_busy is low.
- Latency, m_done to rsp_valid: 1 cycle.
- Minimum spacing between two grants: 4 cycles (IDLE, ISSUE, WAIT, RESP).
- m_done arriving while the FSM is in ISSUE or IDLE is ignored.
- rst asserted mid-transaction returns the FSM to IDLE and clears all outputs on the next edge. No response is issued for the interrupted command. The master is reset by the same rst.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - A counter of clog2(TIMEOUT_CYCLES+1) bits clears on entry to WAIT and increments each cycle in WAIT.
  - When the count reaches TIMEOUT_CYCLES with no m_done, pulse m_abort and go to RESP with rsp_status=10 and rsp_rdata=0.
  - If m_done arrives in the same cycle as expiry, m_done wins and the status is OK or NACK.
- I2C_ARB_TIMEOUT_EN undefined: no counter; m_abort is tied to 0; WAIT lasts indefinitely; status 10 is never produced.

## Test plan
- Reset, then requester 2 write to 0x19 with data 0xA5, m_ack=1 -> req_ready[2] one cycle after req_valid; m_start with m_addr=0x19, m_rw=0, m_wdata=0xA5; rsp_valid[2] with status 00 one cycle after m_done.
- Requester 1 read from 0x19, master returns m_rdata=0x3C with m_ack=1 -> rsp_rdata=0x3C, rsp_status=00.
- All 4 requesters continuously valid -> grant order 0,1,2,3,0; each req_ready is one cycle wide and one-hot.
- m_ack=0 on a write to 0x22 -> rsp_status=01, rsp_rdata=0x00.
- m_busy held high for 5 cycles in ISSUE -> m_start delayed until m_busy falls; req_ready still pulses exactly once.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no m_done -> m_abort pulses after 16 WAIT cycles and rsp_status=10. Without the macro the FSM stays in WAIT indefinitely.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Shares one I2C bus master between NUM_REQ on-chip requesters. Each grant
// carries one single-byte command (7-bit address, R/W, write byte). The command
// goes to the master's command port. The block waits for the master to finish,
// then returns the read byte and status to the granted requester. Arbitration is
// round-robin, starting from the requester after the last one served.
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN
//   Defined   : WAIT is bounded by TIMEOUT_CYCLES. On expiry m_abort pulses and
//               the response carries status 2'b10.
//   Undefined : no counter, m_abort is tied low, and WAIT lasts until m_done.
//
// Ports
//   clk, rst        system clock; synchronous active-high reset
//   req_valid       per-requester command valid; held until req_ready
//   req_addr        packed 7-bit addresses, requester i at [7i+6:7i]
//   req_rw          per-requester R/W (1 = read)
//   req_wdata       packed write bytes, requester i at [8i+7:8i]
//   req_ready       one-cycle one-hot accept pulse
//   rsp_valid       one-cycle one-hot completion pulse
//   rsp_rdata       read byte (zero for writes, NACK and timeout)
//   rsp_status      00 OK, 01 NACK, 10 TIMEOUT
//   grant_id        index of the current or last grant
//   m_start         one-cycle command strobe to the master
//   m_addr/m_rw/m_wdata  command to the master, held from ISSUE through WAIT
//   m_abort         one-cycle abort strobe (timeout build only)
//   m_busy          master busy; delays m_start
//   m_done          one-cycle completion from the master
//   m_ack, m_rdata  completion info, sampled with m_done
// -----------------------------------------------------------------------------
module i2c_bus_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [7*NUM_REQ-1:0]       req_addr,
  input  logic [NUM_REQ-1:0]         req_rw,
  input  logic [8*NUM_REQ-1:0]       req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [7:0]                 rsp_rdata,
  output logic [1:0]                 rsp_status,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       m_start,
  output logic [6:0]                 m_addr,
  output logic                       m_rw,
  output logic [7:0]                 m_wdata,
  output logic                       m_abort,
  input  logic                       m_busy,
  input  logic                       m_done,
  input  logic                       m_ack,
  input  logic [7:0]                 m_rdata
);

  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam int         CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   grant_reg, grant_next;
  logic [ID_W-1:0]   last_grant_reg, last_grant_next;
  logic [6:0]        addr_reg, addr_next;
  logic              rw_reg, rw_next;
  logic [7:0]        wdata_reg, wdata_next;
  logic [7:0]        rdata_reg, rdata_next;
  logic [1:0]        status_reg, status_next;
  // Set after the first ISSUE cycle so req_ready pulses once even when m_busy
  // holds the FSM in ISSUE for several cycles.
  logic              issued_reg, issued_next;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              abort_v;
`endif

  // Unpacked per-requester views of the flat command buses
  logic [6:0] addr_arr  [NUM_REQ];
  logic       rw_arr    [NUM_REQ];
  logic [7:0] wdata_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[7*gi +: 7];
      assign rw_arr[gi]    = req_rw[gi];
      assign wdata_arr[gi] = req_wdata[8*gi +: 8];
    end
  endgenerate

  // Round-robin winner. The search starts at last_grant+1 and wraps. The last
  // requester served is therefore checked last, and a lone requester still wins.
  logic            win_found;
  logic [ID_W-1:0] win_idx;

  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_reg) + k) % NUM_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
      addr_reg       <= '0;
      rw_reg         <= 1'b0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      status_reg     <= ST_OK;
      issued_reg     <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_reg        <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      addr_reg       <= addr_next;
      rw_reg         <= rw_next;
      wdata_reg      <= wdata_next;
      rdata_reg      <= rdata_next;
      status_reg     <= status_next;
      issued_reg     <= issued_next;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_reg        <= cnt_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    addr_next       = addr_reg;
    rw_next         = rw_reg;
    wdata_next      = wdata_reg;
    rdata_next      = rdata_reg;
    status_next     = status_reg;
    issued_next     = 1'b0;
    req_ready       = '0;
    rsp_valid       = '0;
    m_start         = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_next        = cnt_reg;
    abort_v         = 1'b0;
`endif

    unique case (state_reg)
      IDLE: begin
        if (win_found) begin
          grant_next = win_idx;
          addr_next  = addr_arr[win_idx];
          rw_next    = rw_arr[win_idx];
          wdata_next = wdata_arr[win_idx];
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        req_ready[grant_reg] = !issued_reg;
        issued_next          = 1'b1;
        if (!m_busy) begin
          m_start    = 1'b1;
          state_next = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end

      WAIT: begin
        // m_done takes priority over a same-cycle timeout.
        if (m_done) begin
          status_next = m_ack ? ST_OK : ST_NACK;
          rdata_next  = (m_ack && rw_reg) ? m_rdata : 8'h00;
          state_next  = RESP;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES)) begin
          abort_v     = 1'b1;
          status_next = ST_TIMEOUT;
          rdata_next  = 8'h00;
          state_next  = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end

      RESP: begin
        rsp_valid[grant_reg] = 1'b1;
        last_grant_next      = grant_reg;
        state_next           = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

`ifdef I2C_ARB_TIMEOUT_EN
  assign m_abort = abort_v;
`else
  assign m_abort = 1'b0;
`endif

  assign grant_id   = grant_reg;
  assign m_addr     = addr_reg;
  assign m_rw       = rw_reg;
  assign m_wdata    = wdata_reg;
  assign rsp_rdata  = rdata_reg;
  assign rsp_status = status_reg;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter (NUM_REQ=4). Uses table-driven single transactions
// plus hand-written sequences for m_busy stall, mid-transaction reset and WAIT
// timeout behaviour.
module tb_i2c_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [7*N-1:0] req_addr;
  logic [N-1:0]   req_rw;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_rdata;
  logic [1:0]     rsp_status;
  logic [1:0]     grant_id;
  logic           m_start;
  logic [6:0]     m_addr;
  logic           m_rw;
  logic [7:0]     m_wdata;
  logic           m_abort;
  logic           m_busy;
  logic           m_done;
  logic           m_ack;
  logic [7:0]     m_rdata;

  int tests = 0;
  int fails = 0;

  i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .grant_id(grant_id),
    .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
    .m_abort(m_abort), .m_busy(m_busy), .m_done(m_done), .m_ack(m_ack),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] mrdata;
    int         exp_id;
    logic [1:0] exp_status;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Puts the command on lane id. Other lanes get distinct filler values, so a
  // wrong lane select appears on m_addr/m_rw/m_wdata.
  task automatic set_lanes(input int id, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    for (int i = 0; i < N; i++) begin
      req_addr[7*i +: 7]  = (i == id) ? a  : 7'(7'h70 + i);
      req_rw[i]           = (i == id) ? rw : ~rw;
      req_wdata[8*i +: 8] = (i == id) ? wd : 8'(8'hF0 + i);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_status"}, rsp_status, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_m_start"}, m_start, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_rw"}, m_rw, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_m_abort"}, m_abort, 0);
  endtask

  // One complete transaction: it starts in IDLE and ends back in IDLE.
  task automatic do_txn(input vec_t v, input int n);
    logic [3:0] oh;
    oh = 4'(1 << v.exp_id);
    set_lanes(v.exp_id, v.addr, v.rw, v.wdata);
    req_valid = v.valid;
    m_busy = 1'b0;
    m_done = 1'b0;
    #1;
    chk("idle_ready", req_ready, 0);
    tick();                                   // ISSUE
    chk("ready_onehot", req_ready, oh);
    chk("grant_id", grant_id, v.exp_id);
    chk("m_start", m_start, 1);
    chk("m_addr", m_addr, v.addr);
    chk("m_rw", m_rw, v.rw);
    chk("m_wdata", m_wdata, v.wdata);
    req_valid = '0;
    tick();                                   // WAIT
    chk("wait_ready", req_ready, 0);
    chk("wait_m_start", m_start, 0);
    tick();
    tick();
    chk("wait_rsp", rsp_valid, 0);
    m_done = 1'b1;
    m_ack = v.ack;
    m_rdata = v.mrdata;
    tick();                                   // RESP
    m_done = 1'b0;
    m_ack = ~v.ack;
    m_rdata = ~v.mrdata;
    #1;
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_status", rsp_status, v.exp_status);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    $display("[TB] txn %0d: grant=%0d addr=%02h rw=%0b status=%02b rdata=%02h",
             n, grant_id, m_addr, m_rw, rsp_status, rsp_rdata);
    tick();                                   // IDLE
    chk("rsp_gone", rsp_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 300000");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   hits;
    // Fields: valid, addr, rw, wdata, ack, m_rdata, exp_id, exp_status, exp_rdata
    vecs[0]  = '{4'b0100, 7'h19, 1'b0, 8'hA5, 1'b1, 8'h00, 2, 2'b00, 8'h00};
    vecs[1]  = '{4'b0010, 7'h19, 1'b1, 8'h00, 1'b1, 8'h3C, 1, 2'b00, 8'h3C};
    vecs[2]  = '{4'b0001, 7'h22, 1'b0, 8'h5A, 1'b0, 8'h66, 0, 2'b01, 8'h00};
    vecs[3]  = '{4'b1000, 7'h50, 1'b1, 8'h00, 1'b0, 8'h77, 3, 2'b01, 8'h00};
    // All four valid: last grant was 3, so the order is 0,1,2,3,0
    vecs[4]  = '{4'b1111, 7'h11, 1'b1, 8'h00, 1'b1, 8'h81, 0, 2'b00, 8'h81};
    vecs[5]  = '{4'b1111, 7'h12, 1'b0, 8'h42, 1'b1, 8'h99, 1, 2'b00, 8'h00};
    vecs[6]  = '{4'b1111, 7'h13, 1'b1, 8'h00, 1'b1, 8'hC3, 2, 2'b00, 8'hC3};
    vecs[7]  = '{4'b1111, 7'h14, 1'b0, 8'h44, 1'b1, 8'h12, 3, 2'b00, 8'h00};
    vecs[8]  = '{4'b1111, 7'h15, 1'b1, 8'h00, 1'b1, 8'hE5, 0, 2'b00, 8'hE5};
    // Sparse requests: after 0 -> 1, after 1 -> 3 (2 is idle)
    vecs[9]  = '{4'b1010, 7'h2A, 1'b0, 8'h99, 1'b1, 8'h00, 1, 2'b00, 8'h00};
    vecs[10] = '{4'b1010, 7'h2B, 1'b1, 8'h00, 1'b1, 8'h01, 3, 2'b00, 8'h01};
    // Lone requester is granted every turn
    vecs[11] = '{4'b0001, 7'h7E, 1'b1, 8'h00, 1'b1, 8'h5F, 0, 2'b00, 8'h5F};
    vecs[12] = '{4'b0001, 7'h01, 1'b0, 8'hFF, 1'b1, 8'hAA, 0, 2'b00, 8'h00};

    rst = 1'b1;
    req_valid = '0;
    set_lanes(0, 7'h00, 1'b0, 8'h00);
    m_busy = 1'b0;
    m_done = 1'b0;
    m_ack = 1'b0;
    m_rdata = 8'h00;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk_reset_outputs("post_reset");

    for (int i = 0; i < 13; i++) do_txn(vecs[i], i);

    // m_busy holds ISSUE for 5 cycles, and an m_done pulse inside ISSUE is ignored
    set_lanes(3, 7'h33, 1'b0, 8'hBE);
    req_valid = 4'b1000;
    m_busy = 1'b1;
    m_ack = 1'b1;
    tick();
    chk("busy_ready_first", req_ready, 4'b1000);
    chk("busy_no_start", m_start, 0);
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      m_done = (c == 1);
      tick();
      chk("busy_ready_held", req_ready, 0);
      chk("busy_start_held", m_start, 0);
      chk("busy_rsp_held", rsp_valid, 0);
    end
    m_done = 1'b0;
    m_busy = 1'b0;
    #1;
    chk("busy_start_release", m_start, 1);
    chk("busy_ready_release", req_ready, 0);
    chk("busy_m_addr", m_addr, 7'h33);
    tick();
    tick();
    chk("busy_wait_rsp", rsp_valid, 0);
    m_done = 1'b1;
    m_ack = 1'b1;
    m_rdata = 8'h12;
    tick();
    m_done = 1'b0;
    chk("busy_rsp_valid", rsp_valid, 4'b1000);
    chk("busy_rsp_status", rsp_status, 2'b00);
    chk("busy_rsp_rdata", rsp_rdata, 8'h00);
    $display("[TB] txn busy: grant=%0d status=%02b", grant_id, rsp_status);
    tick();

    // Reset in WAIT: outputs clear and no response is issued
    set_lanes(1, 7'h44, 1'b1, 8'h00);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    m_done = 1'b1;
    m_ack = 1'b1;
    m_rdata = 8'h55;
    tick();
    m_done = 1'b0;
    chk("midrst_no_rsp0", rsp_valid, 0);
    tick();
    chk("midrst_no_rsp1", rsp_valid, 0);
    $display("[TB] txn midrst: reset during WAIT");
    // Priority restarts at requester 0
    v = '{4'b1111, 7'h60, 1'b1, 8'h00, 1'b1, 8'h9C, 0, 2'b00, 8'h9C};
    do_txn(v, 100);

    // WAIT without m_done
    set_lanes(2, 7'h21, 1'b1, 8'h00);
    req_valid = 4'b0100;
    m_busy = 1'b0;
    tick();                                   // ISSUE
    req_valid = '0;
    tick();                                   // first WAIT cycle
`ifdef I2C_ARB_TIMEOUT_EN
    hits = 0;
    for (int n = 1; n <= 40; n++) begin
      if (m_abort) begin
        hits = n;
        break;
      end
      tick();
    end
    chk("timeout_abort_cycle", hits, TO + 1);
    tick();
    chk("timeout_rsp_valid", rsp_valid, 4'b0100);
    chk("timeout_status", rsp_status, 2'b10);
    chk("timeout_rdata", rsp_rdata, 8'h00);
    chk("timeout_abort_gone", m_abort, 0);
    $display("[TB] txn timeout: status=%02b", rsp_status);
    tick();
`else
    hits = 0;
    for (int n = 0; n < 40; n++) begin
      if (rsp_valid != 0 || m_abort) hits++;
      tick();
    end
    chk("no_timeout_hold", hits, 0);
    m_done = 1'b1;
    m_ack = 1'b1;
    m_rdata = 8'hD2;
    tick();
    m_done = 1'b0;
    chk("no_timeout_rsp_valid", rsp_valid, 4'b0100);
    chk("no_timeout_status", rsp_status, 2'b00);
    chk("no_timeout_rdata", rsp_rdata, 8'hD2);
    $display("[TB] txn long_wait: status=%02b rdata=%02h", rsp_status, rsp_rdata);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
